// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: state encodings, reset/write levels and helpers.
// The optional checksum stage (BOOT_CHECKSUM_EN) reuses StCsum defined here.
package boot_loader_pkg;

  localparam logic [2:0] StHdrHi = 3'd0;
  localparam logic [2:0] StHdrLo = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StCsum  = 3'd3;
  localparam logic [2:0] StRun   = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  localparam logic RstEnable   = 1'b1;
  localparam logic RstDisable  = 1'b0;
  localparam logic WriteEnable = 1'b1;

  localparam int unsigned BootWordBytes = 4;

  // States in which the loader consumes stream bytes.
  function automatic logic is_accepting(input logic [2:0] st);
    return (st == StHdrHi) || (st == StHdrLo) || (st == StLoad) || (st == StCsum);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
interface boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/boot_loader_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_valid_o marks the 4th byte.
module boot_loader_word_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LastIdx = 2'(BootWordBytes - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The final byte completes the word combinationally so the top can register it directly.
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (cnt_q == LastIdx);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_o[23:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into instruction RAM and holds the CPU in reset until it is loaded.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte over the payload.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output logic          cpu_rst_o,
  output logic          boot_done_o,
  output logic          boot_err_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] StAfterLoad = StCsum;
`else
  localparam logic [2:0] StAfterLoad = StRun;
`endif

  logic [2:0]            state_q, state_d;
  logic [7:0]            hdr_hi_q, hdr_hi_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           widx_q, widx_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic                  cpu_rst_q, boot_done_q, boot_err_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] hdr_count;
  logic [31:0] pk_word;
  logic        pk_word_valid;

  assign accept    = bus.rx_valid && is_accepting(state_q);
  assign hdr_count = {hdr_hi_q, bus.rx_data};

  boot_loader_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q != StLoad),
    .byte_valid_i (accept && (state_q == StLoad)),
    .byte_i       (bus.rx_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    hdr_hi_d    = hdr_hi_q;
    count_d     = count_q;
    widx_d      = widx_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      StHdrHi: begin
        if (accept) begin
          hdr_hi_d = bus.rx_data;
          state_d  = StHdrLo;
        end
      end
      StHdrLo: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count == 16'd0) begin
            state_d = StAfterLoad;
          end else if (32'(hdr_count) > Depth) begin
            state_d = StErr;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
`ifdef BOOT_CHECKSUM_EN
        if (accept) begin
          csum_d = csum_q ^ bus.rx_data;
        end
`endif
        if (pk_word_valid) begin
          ram_we_d    = WriteEnable;
          ram_wdata_d = pk_word;
          ram_addr_d  = widx_q[ADDR_WIDTH-1:0];
          widx_d      = widx_q + 16'd1;
          // Leaving LOAD here lands the state change on the write pulse cycle.
          if (widx_q == count_q - 16'd1) begin
            state_d = StAfterLoad;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (bus.rx_data == csum_q) ? StRun : StErr;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= StHdrHi;
      hdr_hi_q    <= '0;
      count_q     <= '0;
      widx_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rst_q   <= RstEnable;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_hi_q    <= hdr_hi_d;
      count_q     <= count_d;
      widx_q      <= widx_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rst_q   <= (state_q == StRun) ? RstDisable : RstEnable;
      boot_done_q <= (state_q == StRun);
      boot_err_q  <= (state_q == StErr);
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Gated by rst so the stream sees not-ready while reset is held.
  assign bus.rx_ready  = is_accepting(state_q) && (rst != RstEnable);
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign cpu_rst_o     = cpu_rst_q;
  assign boot_done_o   = boot_done_q;
  assign boot_err_o    = boot_err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader (checksum cases only when BOOT_CHECKSUM_EN is set).
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst, boot_done, boot_err;
  int   checks = 0;
  int   errors = 0;

  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  logic [7:0] img [10] = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05,
                           8'h24, 8'h02, 8'h00, 8'h07};

  boot_loader_if #(.ADDR_WIDTH(10)) bus ();

  boot_loader #(.ADDR_WIDTH(10)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cpu_rst_o   (cpu_rst),
    .boot_done_o (boot_done),
    .boot_err_o  (boot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wr_addr.push_back(bus.ram_addr);
      wr_data.push_back(bus.ram_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    check("send_accept", acc, 1'b1);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_ram_addr", bus.ram_addr, 10'h000);
    check("rst_ram_wdata", bus.ram_wdata, 32'h0);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_boot_done", boot_done, 1'b0);
    check("rst_boot_err", boot_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", bus.rx_ready, 1'b1);
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_image_writes(input string tag);
    check({tag, "_nwrites"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, wr_addr[0], 10'd0);
      check({tag, "_data0"}, wr_data[0], 32'h2401_0005);
      check({tag, "_addr1"}, wr_addr[1], 10'd1);
      check({tag, "_data1"}, wr_data[1], 32'h2402_0007);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(2);

    // Test 1: two-word image, one byte per cycle.
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(img[i]);
`ifdef BOOT_CHECKSUM_EN
    @(negedge clk);
    check("t1_we_last", bus.ram_we, 1'b1);
    check("t1_addr_last", bus.ram_addr, 10'd1);
    check("t1_csum_ready", bus.rx_ready, 1'b1);
    @(posedge clk);
    #1;
    send_byte(8'h01);
`else
    @(negedge clk);
    check("t1_we_last", bus.ram_we, 1'b1);
    check("t1_addr_last", bus.ram_addr, 10'd1);
    check("t1_cpu_rst_held", cpu_rst, 1'b1);
    check("t1_ready_run", bus.rx_ready, 1'b0);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_cpu_rst_rel", cpu_rst, 1'b0);
    check("t1_boot_done", boot_done, 1'b1);
    check("t1_we_pulse_end", bus.ram_we, 1'b0);
    check_image_writes("t1");

    // Test 2: same image with random valid gaps, then trailing bytes after load.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(1, 5));
      send_byte(img[i]);
    end
`ifdef BOOT_CHECKSUM_EN
    idle($urandom_range(1, 5));
    send_byte(8'h01);
`endif
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    idle(4);
    bus.rx_valid = 1'b0;
    check("t2_boot_done", boot_done, 1'b1);
    check("t2_cpu_rst", cpu_rst, 1'b0);
    check_image_writes("t2");

    // Test 3: empty image.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    @(negedge clk);
    check("t3_csum_ready", bus.rx_ready, 1'b1);
    @(posedge clk);
    #1;
    send_byte(8'h00);
`endif
    @(negedge clk);
    check("t3_done_early", boot_done, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_boot_done", boot_done, 1'b1);
    check("t3_cpu_rst", cpu_rst, 1'b0);
    check("t3_nwrites", wr_addr.size(), 0);

    // Test 4: count of DEPTH+1 words is rejected; trailing bytes are ignored.
    do_reset();
    send_byte(8'h04);
    send_byte(8'h01);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h24;
    idle(3);
    @(negedge clk);
    check("t4_boot_err", boot_err, 1'b1);
    check("t4_cpu_rst", cpu_rst, 1'b1);
    check("t4_rx_ready", bus.rx_ready, 1'b0);
    check("t4_boot_done", boot_done, 1'b0);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    check("t4_nwrites", wr_addr.size(), 0);

    // Test 4b: count of exactly DEPTH words is accepted into LOAD.
    do_reset();
    send_byte(8'h04);
    send_byte(8'h00);
    idle(2);
    @(negedge clk);
    check("t4b_boot_err", boot_err, 1'b0);
    check("t4b_rx_ready", bus.rx_ready, 1'b1);
    @(posedge clk);
    #1;

`ifdef BOOT_CHECKSUM_EN
    // Test 5: checksum mismatch rejects the image.
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(img[i]);
    send_byte(8'h07);
    idle(2);
    @(negedge clk);
    check("t5_boot_err", boot_err, 1'b1);
    check("t5_cpu_rst", cpu_rst, 1'b1);
    check("t5_boot_done", boot_done, 1'b0);
    @(posedge clk);
    #1;
`endif

    // Test 6: reset after five payload bytes, then a clean reload.
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(img[i]);
    check("t6_wdata_pre", bus.ram_wdata, 32'h2401_0005);
    rst = 1'b1;
    #1;
    check("t6_wdata_rst", bus.ram_wdata, 32'h0);
    check("t6_addr_rst", bus.ram_addr, 10'd0);
    check("t6_cpu_rst", cpu_rst, 1'b1);
    check("t6_ready_rst", bus.rx_ready, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(img[i]);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h01);
`endif
    idle(2);
    check("t6_boot_done", boot_done, 1'b1);
    check_image_writes("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
